cmp_serial_arb: RTL
===================

CMP_SERIAL_ARB -- requirements
Module: cmp_serial_arb

Interface
REQ-001 Parameter WIDTH, default 10, is the operand width in bits; legal range 2..16.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i belongs to requester i.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-006 a0, b0  input  WIDTH each  requester 0 operands, unsigned.
REQ-007 a1, b1  input  WIDTH each  requester 1 operands, unsigned.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  result consumer accept.
REQ-010 res_id  output  1  index of the requester that owns the current result.
REQ-011 gt, eq, lt  output  1 each  result flags: A>B, A==B, A<B; exactly one high while res_valid is high.
REQ-012 busy  output  1  high in every state other than IDLE.

Function
REQ-013 The FSM has three states: IDLE, RUN and DONE.
REQ-014 IDLE: req_ready asserts only for the granted requester; grant is the sole valid requester, or the requester named by the priority pointer when both are valid.
REQ-015 A request is accepted on an edge with req_valid[i] & req_ready[i]; its operands and id are captured and the FSM moves to RUN; req_ready is 0 outside IDLE.
REQ-016 On each accept, the priority pointer changes to the other requester, giving round-robin fairness; it does not change when nothing is accepted.
REQ-017 RUN: the block processes one bit per cycle, LSB first, bit index 0..WIDTH-1, for exactly WIDTH cycles.
REQ-018 Per-bit recurrence, with running flags G/E/L initialised to 0/1/0 at accept:
- E' = E & (A[k] xnor B[k])
- G' = (A[k] & ~B[k]) | (G & (A[k] xnor B[k]))
- L' = (~A[k] & B[k]) | (L & (A[k] xnor B[k]))
REQ-019 After the bit WIDTH-1 update, the FSM enters DONE; res_valid goes high exactly WIDTH+1 cycles after the accept edge.
REQ-020 DONE: res_valid, res_id, gt, eq and lt hold stable until a res_valid & res_ready edge; on that edge the FSM returns to IDLE.
REQ-021 gt, eq and lt are 0 whenever res_valid is 0.
REQ-022 The handshake edge that leaves DONE does not accept a new request; the earliest next accept is the following edge, so the minimum accept-to-accept period is WIDTH+2 cycles with res_ready tied high.
REQ-023 Operand changes on a0/b0/a1/b1 after accept do not affect the in-flight result.
REQ-024 A requester that drops req_valid before being granted is not served; no request is queued internally.
REQ-025 Operands all-zero and all-ones are legal and produce eq=1.

Reset
REQ-026 When rst is high at an edge, the FSM enters IDLE from any state, including mid-RUN and DONE; any in-flight result is discarded.
REQ-027 After reset: priority pointer=0, req_ready=2'b00 during reset, res_valid=0, res_id=0, gt=eq=lt=0, busy=0; all captured operands and the bit counter are 0.
REQ-028 In the first cycle after rst deasserts, req_ready follows REQ-014.

Verification (WIDTH=10)
REQ-029 Requester 0 only, a0=10'd500, b0=10'd499, res_ready=1 -> accept at edge T; res_valid high from T+11 for one cycle; gt=1, res_id=0.
REQ-030 Both valid from reset, with r0 (a0=3, b0=3) and r1 (a1=7, b1=640) -> r0 is granted first with eq=1; r1 is granted next with lt=1, res_id=1; the pointer then equals 0.
REQ-031 a0=10'h3FF and b0=10'h3FF, followed by a0=0 and b0=0 -> both results give eq=1; also a0=10'h200, b0=10'h1FF -> gt=1, which checks that the MSB dominates lower bits.
REQ-032 Result backpressure: res_ready=0 for 5 cycles in DONE -> outputs stay stable, req_ready=0, and a new request waits; the next accept comes one edge after the res_ready handshake.
REQ-033 Assert rst in the 4th RUN cycle -> next cycle busy=0, res_valid=0 and the pointer is 0; no result for the aborted request appears.
REQ-034 Random stress: 10k random requests from both requesters with random res_ready -> every result matches an unsigned compare; exactly one of gt/eq/lt is high; req_ready is one-hot or zero; no requester is starved for more than one other grant.

Source files
------------

// File: rtl/cmp_serial_arb.sv
// Two-requester round-robin arbiter feeding a bit-serial unsigned comparator.
// One compare in flight; result held in DONE until consumer handshake.
module cmp_serial_arb #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             ptr;
  logic             id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  logic             g_q;
  logic             e_q;
  logic             l_q;

  logic [1:0]       grant;
  logic             ab;
  logic             bb;
  logic             same;
  logic             g_n;
  logic             e_n;
  logic             l_n;

  // Grant only in IDLE; the pointer breaks ties when both requesters are valid.
  always_comb begin
    grant = 2'b00;
    if (!rst && state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign busy      = (state != IDLE);

  // Next running flags for the current bit; higher bits override lower ones.
  always_comb begin
    ab   = a_q[cnt];
    bb   = b_q[cnt];
    same = ~(ab ^ bb);
    e_n  = e_q & same;
    g_n  = (ab & ~bb) | (g_q & same);
    l_n  = (~ab & bb) | (l_q & same);
  end

  // Main FSM: capture on accept, shift through bits, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      id        <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      g_q       <= 1'b0;
      e_q       <= 1'b1;
      l_q       <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            state <= RUN;
            id    <= grant[1];
            ptr   <= ~grant[1];
            a_q   <= grant[1] ? a1 : a0;
            b_q   <= grant[1] ? b1 : b0;
            cnt   <= '0;
            g_q   <= 1'b0;
            e_q   <= 1'b1;
            l_q   <= 1'b0;
          end
        end
        RUN: begin
          g_q <= g_n;
          e_q <= e_n;
          l_q <= l_n;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_id    <= id;
            gt        <= g_n;
            eq        <= e_n;
            lt        <= l_n;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            gt        <= 1'b0;
            eq        <= 1'b0;
            lt        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
